// File: rtl/pipe_add_sched_if.sv
// Requester/response bundle for pipe_add_sched: N requesters sharing one adder,
// plus the single response stream coming back out of the adder pipeline.
interface pipe_add_sched_if #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_cin;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic [W-1:0]    rsp_sum;
    logic            rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/pipe_add_sched.sv
// Round-robin scheduler feeding an external LAT-stage pipelined adder; a tag
// shift register tracks which requester owns each result emerging from the adder.
module pipe_add_sched #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int LAT  = 3,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    pipe_add_sched_if.slave          bus,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    output logic                     add_c_in,
    input  logic [W-1:0]             add_sum,
    input  logic                     add_c_out,
    output logic [$clog2(LAT+1)-1:0] inflight
);
    localparam int CNT_W = $clog2(LAT + 1);

    logic [ID_W-1:0]  last_grant_r;
    logic [ID_W-1:0]  grant_idx_s;
    logic [ID_W-1:0]  cand_idx_s;
    logic             grant_s;
    logic             hs_s;
    logic [N-1:0]     ready_s;
    logic [LAT-1:0]   tag_v_r;
    logic [ID_W-1:0]  tag_id_r [LAT];
    logic [CNT_W-1:0] inflight_r;

    // Round-robin search starting one past the last granted requester; gated by reset too
    always_comb begin
        ready_s     = '0;
        grant_s     = 1'b0;
        grant_idx_s = '0;
        cand_idx_s  = '0;
        if (rst_n && enable) begin
            for (int off = 1; off <= N; off++) begin
                cand_idx_s = ID_W'((int'(last_grant_r) + off) % N);
                if (!grant_s && bus.req_valid[cand_idx_s]) begin
                    grant_s     = 1'b1;
                    grant_idx_s = cand_idx_s;
                end else begin
                    grant_s     = grant_s;
                end
            end
            if (grant_s) begin
                ready_s[grant_idx_s] = 1'b1;
            end else begin
                ready_s = '0;
            end
        end else begin
            ready_s = '0;
        end
    end

    assign bus.req_ready = ready_s;
    assign hs_s          = |(bus.req_valid & ready_s);

    // Steer the granted requester's operands to the adder; idle inputs are zero
    always_comb begin
        if (grant_s) begin
            add_a    = bus.req_a[grant_idx_s*W +: W];
            add_b    = bus.req_b[grant_idx_s*W +: W];
            add_c_in = bus.req_cin[grant_idx_s];
        end else begin
            add_a    = '0;
            add_b    = '0;
            add_c_in = 1'b0;
        end
    end

    // Pointer moves only on an accepted transfer; reset gives requester 0 first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= ID_W'(N - 1);
        end else if (hs_s) begin
            last_grant_r <= grant_idx_s;
        end
    end

    // Tag pipeline mirrors the adder latency; invalid slots carry id 0 so rsp_id idles at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_v_r[0]  <= hs_s;
            tag_id_r[0] <= hs_s ? grant_idx_s : '0;
            for (int i = 1; i < LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Outstanding-operation count: issue adds one, retire subtracts one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= '0;
        end else begin
            case ({hs_s, tag_v_r[LAT-1]})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    assign bus.rsp_valid = tag_v_r[LAT-1];
    assign bus.rsp_id    = tag_id_r[LAT-1];
    assign bus.rsp_sum   = add_sum;
    assign bus.rsp_cout  = add_c_out;
    assign inflight      = inflight_r;
endmodule
